// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM states,
// requester channel indices and the protocol byte values used by requesters.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int REQ_GESTURE = 0;
    localparam int REQ_STATUS  = 1;
    localparam int REQ_CONFIG  = 2;
    localparam int REQ_ECHO    = 3;

    localparam logic [7:0] SYNC_BYTE  = 8'h55;
    localparam logic [7:0] HDR_STATUS = 8'hA0;
    localparam logic [7:0] HDR_CONFIG = 8'hB0;

    // Byte 0 of a packet is the high byte of the 16-bit payload.
    function automatic logic [7:0] pick_byte(input logic [15:0] data, input logic idx);
        return idx ? data[7:0] : data[15:8];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: one-hot grant for the first asserted
// request at or after ptr, wrapping around; all zero when nothing requests.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    localparam int IW = $clog2(N);

    logic [IW:0] pos;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int off = 0; off < N; off++) begin
            // ptr < N and off < N, so one conditional subtract is a full modulo.
            pos = {1'b0, ptr} + (IW+1)'(off);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found && req[pos[IW-1:0]]) begin
                grant[pos[IW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that accepts 1- or 2-byte packets from NUM_REQ channels
// and feeds them byte by byte to a UART transmitter using its busy flag.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_len,
    input  logic [NUM_REQ*16-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_busy,
    output logic                       active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    // Handshake: valid/ready both high on a rising edge transfers the packet;
    // ready is only ever offered in IDLE and never while rst is high.

    arb_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic          byte_idx_q, byte_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   data_q, data_d;
    logic          len_q, len_d;

    logic [NUM_REQ-1:0] pick;
    logic               hs;
    logic [IW-1:0]      hs_idx;
    logic [15:0]        hs_data;
    logic               hs_len;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick)
    );

    always_comb begin
        hs_idx  = '0;
        hs_data = '0;
        hs_len  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                hs_idx  = IW'(i);
                hs_data = req_data[16*i +: 16];
                hs_len  = req_len[i];
            end
        end
    end

    assign hs = (state_q == ST_IDLE) && (|pick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            byte_idx_q <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            len_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            byte_idx_q <= byte_idx_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            len_q      <= len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        byte_idx_d = byte_idx_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        len_d      = len_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    data_d     = hs_data;
                    len_d      = hs_len;
                    grant_id_d = hs_idx;
                    rr_ptr_d   = (hs_idx == IDX_LAST) ? '0 : hs_idx + 1'b1;
                    byte_idx_d = 1'b0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    // Saturating: the timeout exit below fires long before all-ones.
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (byte_idx_q == len_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_idx_d = 1'b1;
                        state_d    = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        timeout_err = 1'b0;
        active      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (!rst) begin
                    req_ready = pick;
                end
            end
            ST_SEND: begin
                tx_data  = pick_byte(data_q, byte_idx_q);
                tx_valid = !tx_busy;
            end
            ST_WAIT_BUSY: begin
                timeout_err = !tx_busy && (cnt_q == CNT_LAST);
            end
            default: ;
        endcase
    end

    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a packet-level model (expected byte queue,
// round-robin pointer, busy-rise timer) checked every cycle, plus directed cases.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 16;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_len;
    logic [NUM_REQ*16-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_busy;
    logic                  active;
    logic [1:0]            grant_id;
    logic                  timeout_err;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_len     (req_len),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_busy     (tx_busy),
        .active      (active),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model state
    logic [7:0]         exp_q[$];
    logic [7:0]         tx_log[$];
    int                 tx_cyc_log[$];
    int                 hs_log[$];
    int                 cyc = 0;
    int                 m_ptr = 0;
    int                 m_gid = 0;
    logic               armed = 1'b0;
    int                 since = 0;
    logic               prev_txv = 1'b0;
    logic               prev_hs = 1'b0;
    logic               prev_active = 1'b0;
    int                 tx_count = 0;
    int                 last_tx_cycle = 0;
    int                 hs_cycle = 0;
    int                 to_count = 0;
    int                 to_cycle = 0;
    int                 fall_cycle = 0;
    logic               busy_seen = 1'b0;
    logic               busy_stuck = 1'b0;
    logic [NUM_REQ-1:0] hs_clear = '0;
    logic [NUM_REQ-1:0] hs_mask;
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_to;
    int                 hs_idx;

    function automatic logic [NUM_REQ-1:0] rr_model(input logic [NUM_REQ-1:0] v, input int ptr);
        logic [NUM_REQ-1:0] r;
        int j;
        r = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (ptr + k) % NUM_REQ;
            if (v[j]) begin
                r[j] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // scoreboard / compare process
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_ptr       = 0;
            m_gid       = 0;
            armed       = 1'b0;
            prev_txv    = 1'b0;
            prev_hs     = 1'b0;
            prev_active = 1'b0;
        end else begin
            exp_ready = active ? '0 : rr_model(req_valid, m_ptr);
            check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("grant_id", 32'(grant_id), m_gid);
            if (prev_hs) check("active_after_hs", 32'(active), 32'd1);
            if (tx_busy) busy_seen = 1'b1;
            if (tx_valid) begin
                check("tx_gap", 32'(prev_txv), 32'd0);
                check("busy_low_at_tx", 32'(tx_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected: got tx_valid with data %0h, expected no byte pending", tx_data);
                end else begin
                    check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                tx_log.push_back(tx_data);
                tx_cyc_log.push_back(cyc);
                tx_count++;
                last_tx_cycle = cyc;
                armed = 1'b1;
                since = 0;
            end else if (armed) begin
                if (tx_busy) armed = 1'b0;
                else since++;
            end
            exp_to = armed && !tx_valid && (since == BUSY_TIMEOUT);
            check("timeout_err", 32'(timeout_err), 32'(exp_to));
            if (timeout_err) begin
                to_count++;
                to_cycle = cyc;
            end
            if (exp_to) armed = 1'b0;
            if (prev_active && !active) fall_cycle = cyc;
            hs_mask = req_valid & req_ready;
            prev_hs = (hs_mask != '0);
            if (hs_mask != '0) begin
                hs_idx = 0;
                for (int i = 0; i < NUM_REQ; i++) if (hs_mask[i]) hs_idx = i;
                exp_q.push_back(req_data[16*hs_idx+8 +: 8]);
                if (req_len[hs_idx]) exp_q.push_back(req_data[16*hs_idx +: 8]);
                m_ptr    = (hs_idx + 1) % NUM_REQ;
                m_gid    = hs_idx;
                hs_cycle = cyc;
                hs_log.push_back(hs_idx);
                hs_clear = hs_mask;
            end
            prev_txv    = tx_valid;
            prev_active = active;
        end
    end

    // requesters drop valid after their handshake edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            req_valid = req_valid & ~hs_clear;
            hs_clear  = '0;
        end
    end

    // UART model: busy rises 2 cycles after tx_valid and stays high 10 cycles
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_valid && !busy_stuck) begin
                repeat (2) @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic set_req(input int ch, input logic len, input logic [15:0] data);
        req_len[ch]           = len;
        req_data[16*ch +: 16] = data;
        req_valid[ch]         = 1'b1;
    endtask

    task automatic send_req(input int ch, input logic len, input logic [15:0] data);
        @(posedge clk);
        #1;
        set_req(ch, len, data);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (!active && n < bound) begin
            @(negedge clk);
            n++;
        end
        while (active && n < bound) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (n >= bound) begin
            tests++;
            fails++;
            $display("FAIL %s: no return to IDLE within %0d cycles, got active=%0b expected 0", name, bound, active);
        end
    endtask

    int base;
    int hbase;
    int n;

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_len   = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);

        // single 1-byte packet on the echo channel
        base      = tx_count;
        busy_seen = 1'b0;
        send_req(REQ_ECHO, 1'b0, {SYNC_BYTE, 8'hC3});
        wait_idle("t1_idle", 60);
        check("t1_tx_count", tx_count - base, 1);
        check("t1_byte", 32'(tx_log[base]), 32'h55);
        check("t1_latency", last_tx_cycle - hs_cycle, 1);
        check("t1_busy_seen", 32'(busy_seen), 32'd1);
        check("t1_busy_low_at_fall", 32'(tx_busy), 32'd0);
        check("t1_fall_delay", fall_cycle - last_tx_cycle, 13);
        check("t1_grant_id", 32'(grant_id), 32'd3);

        // 2-byte packet on channel 0
        base = tx_count;
        send_req(REQ_GESTURE, 1'b1, 16'hA19C);
        wait_idle("t2_idle", 80);
        check("t2_tx_count", tx_count - base, 2);
        check("t2_byte0", 32'(tx_log[base]), 32'hA1);
        check("t2_byte1", 32'(tx_log[base+1]), 32'h9C);
        check("t2_gap", tx_cyc_log[base+1] - tx_cyc_log[base], 13);

        // three channels at once, pointer is now 1
        base  = tx_count;
        hbase = hs_log.size();
        @(posedge clk);
        #1;
        set_req(REQ_GESTURE, 1'b0, {HDR_CONFIG, 8'h00});
        set_req(REQ_STATUS, 1'b0, {HDR_STATUS, 8'h00});
        set_req(REQ_CONFIG, 1'b0, 16'h7700);
        n = 0;
        while (!(hs_log.size() >= hbase + 3 && !active) && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL t3_wait: got %0d grants expected 3 within 200 cycles", hs_log.size() - hbase);
        end
        check("t3_grant0", hs_log[hbase], 1);
        check("t3_grant1", hs_log[hbase+1], 2);
        check("t3_grant2", hs_log[hbase+2], 0);
        check("t3_byte0", 32'(tx_log[base]), 32'hA0);
        check("t3_byte1", 32'(tx_log[base+1]), 32'h77);
        check("t3_byte2", 32'(tx_log[base+2]), 32'hB0);

        // busy never rises: timeout
        busy_stuck = 1'b1;
        base       = to_count;
        send_req(REQ_CONFIG, 1'b0, {HDR_CONFIG, 8'h5A});
        wait_idle("t4_idle", 60);
        check("t4_timeouts", to_count - base, 1);
        check("t4_timeout_delay", to_cycle - last_tx_cycle, 16);
        check("t4_fall_after_timeout", fall_cycle - to_cycle, 2);
        busy_stuck = 1'b0;
        repeat (2) @(posedge clk);

        // reset between the two bytes of a packet
        base = tx_count;
        send_req(REQ_STATUS, 1'b1, 16'h1234);
        n = 0;
        while (tx_count == base && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        #1;
        check("t5_mid_active", 32'(active), 32'd1);
        req_valid[REQ_ECHO] = 1'b1;
        req_data[16*REQ_ECHO +: 16] = 16'hEEEE;
        #1 rst = 1'b1;
        #1;
        check("t5_rst_active", 32'(active), 32'd0);
        check("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("t5_rst_tx_data", 32'(tx_data), 32'd0);
        check("t5_rst_req_ready", 32'(req_ready), 32'd0);
        check("t5_rst_grant_id", 32'(grant_id), 32'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("t5_no_second_byte", tx_count - base, 1);
        check("t5_idle_after", 32'(active), 32'd0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester channels, range 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 16: maximum cycles to wait for tx_busy to rise after a tx_valid pulse.
REQ-003 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port req_valid, input, NUM_REQ: per-channel packet request.
REQ-006 Port req_len, input, NUM_REQ: per-channel length; 0 means 1 byte, 1 means 2 bytes.
REQ-007 Port req_data, input, NUM_REQ*16: per-channel payload; channel i occupies [16i+15:16i]; the high byte is sent first.
REQ-008 Port req_ready, output, NUM_REQ: one-hot accept; the packet transfers on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 Port tx_data, output, 8: byte to the UART transmitter.
REQ-010 Port tx_valid, output, 1: one-cycle send strobe to the UART transmitter.
REQ-011 Port tx_busy, input, 1: UART transmitter busy flag.
REQ-012 Port active, output, 1: high in any state other than IDLE.
REQ-013 Port grant_id, output, clog2(NUM_REQ): channel currently being served; holds the last value while IDLE.
REQ-014 Port timeout_err, output, 1: one-cycle pulse on a busy-rise timeout.

Function
REQ-015 FSM states are IDLE, SEND, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE, arbitration:
- req_ready is combinational and one-hot, selecting the first asserted req_valid at or after rr_ptr (wrap-around search).
- When no req_valid is asserted, req_ready is all zero.
- req_ready is all zero in every non-IDLE state.
REQ-017 IDLE, handshake:
- On a handshake for channel i, latch req_data[i] and req_len[i].
- Set grant_id to i and rr_ptr to (i+1) mod NUM_REQ.
- Clear byte_idx and go to SEND.
REQ-018 SEND, tx_busy low: drive tx_data with the current byte, pulse tx_valid for one cycle, clear the timeout counter, go to WAIT_BUSY.
REQ-019 SEND, tx_busy high: hold, with no tx_valid.
REQ-020 WAIT_BUSY, tx_busy high: go to WAIT_DONE.
REQ-021 WAIT_BUSY, tx_busy low: increment the counter; when the counter reaches BUSY_TIMEOUT-1, pulse timeout_err and go to WAIT_DONE.
REQ-022 WAIT_DONE, tx_busy low:
- If byte_idx equals req_len, go to IDLE.
- Otherwise increment byte_idx and go to SEND.
REQ-023 Earliest tx_valid is 1 cycle after the handshake edge; between consecutive bytes of a packet there is at least one cycle with tx_busy low.
REQ-024 tx_valid never asserts outside SEND and never on two consecutive cycles.
REQ-025 Requesters hold req_valid, req_len and req_data stable until the handshake; the arbiter samples them only on the handshake edge.
REQ-026 If several channels are valid at once, round-robin order applies; no channel waits more than NUM_REQ-1 other packets.
REQ-027 A new request arriving mid-packet is not accepted until the return to IDLE.
REQ-028 The counter saturates and does not wrap.

Reset
REQ-029 On assertion of rst, asynchronously:
- state is IDLE, rr_ptr 0, grant_id 0, byte_idx 0, counter 0;
- tx_data is 0x00, and tx_valid, timeout_err and active are 0;
- req_ready is all zero during reset.
REQ-030 Reset mid-packet aborts the packet without completing it; no tx_valid is issued until a fresh handshake after reset release.

Structure
REQ-031 Shared package uart_arb_pkg holds the FSM state enum, requester index constants (REQ_GESTURE=0, REQ_STATUS=1, REQ_CONFIG=2, REQ_ECHO=3) and the protocol byte constants 0x55, 0xA0 and 0xB0.
REQ-032 The round-robin search is a separate combinational sub-module, rr_pick, with inputs req and ptr and a one-hot output grant.

Verification
REQ-033 Single 1-byte request on channel 3 with data 0x55xx, tx_busy modelled 2 cycles after tx_valid for 10 cycles -> one tx_valid with tx_data 0x55, active falls after busy falls.
REQ-034 Channel 0 with a 2-byte packet 0xA1 then 0x9C -> tx_data 0xA1 then 0x9C, each preceded by tx_busy low, and exactly two tx_valid pulses.
REQ-035 Channels 0, 1 and 2 valid simultaneously with rr_ptr 1 -> grant order 1, 2, 0; req_ready is one-hot on each handshake.
REQ-036 tx_busy stuck low after tx_valid -> timeout_err pulses exactly BUSY_TIMEOUT cycles later (16), then the FSM returns to IDLE.
REQ-037 rst asserted between the two bytes of a 2-byte packet -> outputs return to reset values immediately, and no second byte is sent after release.
